// File: rtl/icmp_sched_pkg.sv
// Shared definitions for the ICMP receive scheduler.
//   state_t        : classification state machine encoding
//   drop_reason_t  : why a packet was refused at its first byte
//   IP_PROTO_ICMP  : IP protocol number of ICMP
//   sat_inc        : increment that sticks at the all-ones value of a given width
package icmp_sched_pkg;

  localparam logic [7:0] IP_PROTO_ICMP = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PASS,
    ST_SKIP
  } state_t;

  typedef enum logic [1:0] {
    DROP_NONE,
    DROP_POLICY,
    DROP_BUSY,
    DROP_RATE
  } drop_reason_t;

  // Works on a 32-bit container; width selects where the value saturates.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
    logic [31:0] limit;
    limit = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (value >= limit) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/icmp_rx_scheduler_if.sv
// Byte stream between the IP receive parser, the scheduler and the ICMP responder.
//   ip_rx_enable / ip_rx_data     : payload bytes from the IP parser
//   ip_protocol / ip_broadcast    : header fields, stable for the whole packet
//   icmp_rx_enable / icmp_rx_data : gated, registered stream to the responder
// master = parser/responder side, slave = scheduler.
interface icmp_rx_scheduler_if;
  logic       ip_rx_enable;
  logic [7:0] ip_rx_data;
  logic [7:0] ip_protocol;
  logic       ip_broadcast;
  logic       icmp_rx_enable;
  logic [7:0] icmp_rx_data;

  modport master (
    output ip_rx_enable, ip_rx_data, ip_protocol, ip_broadcast,
    input  icmp_rx_enable, icmp_rx_data
  );

  modport slave (
    input  ip_rx_enable, ip_rx_data, ip_protocol, ip_broadcast,
    output icmp_rx_enable, icmp_rx_data
  );
endinterface

// File: rtl/icmp_token_bucket.sv
// Rate limiter for accepted ICMP packets.
//   rx_clock, reset : clock and synchronous active-high reset
//   consume         : one token is taken this cycle (only asserted when nonzero)
//   tokens          : current token count, BUCKET_MAX after reset
//   nonzero         : at least one token is available
// One token is added every REFILL_DIV cycles, saturating at BUCKET_MAX.
module icmp_token_bucket #(
  parameter int BUCKET_MAX = 4,
  parameter int REFILL_DIV = 125000,
  parameter int TOK_W      = 3
) (
  input  logic             rx_clock,
  input  logic             reset,
  input  logic             consume,
  output logic [TOK_W-1:0] tokens,
  output logic             nonzero
);

  localparam int DIV_W = $clog2(REFILL_DIV);

  logic [DIV_W-1:0] div_count;
  logic             tick;

  assign tick    = (div_count == DIV_W'(REFILL_DIV - 1));
  assign nonzero = (tokens != '0);

  // Free-running refill divider; the terminal count is the refill tick.
  always_ff @(posedge rx_clock) begin
    if (reset)
      div_count <= '0;
    else if (tick)
      div_count <= '0;
    else
      div_count <= div_count + DIV_W'(1);
  end

  // A tick and a consume in the same cycle cancel out.
  always_ff @(posedge rx_clock) begin
    if (reset) begin
      tokens <= TOK_W'(BUCKET_MAX);
    end else if (tick && !consume) begin
      if (tokens != TOK_W'(BUCKET_MAX))
        tokens <= tokens + TOK_W'(1);
    end else if (consume && !tick) begin
      tokens <= tokens - TOK_W'(1);
    end
  end

endmodule

// File: rtl/icmp_rx_scheduler.sv
// Per-datagram gate in front of the ICMP echo responder.
//   rx_clock, reset   : clock and synchronous active-high reset
//   rx                : IP byte stream in, gated ICMP byte stream out
//   cfg_icmp_en       : 0 drops all ICMP
//   cfg_bcast_en      : 0 drops broadcast ICMP
//   resp_busy         : responder not idle, sampled at packet start only
//   dst_unreach       : destination-unreachable pulse from the responder
//   clear_counters    : zeroes all statistics counters
//   tokens            : rate-limit tokens available
//   *_count           : saturating statistics
// A packet is forwarded whole or not at all; the decision is taken on its
// first byte and the stream is delayed by one register stage.
import icmp_sched_pkg::*;

module icmp_rx_scheduler #(
  parameter int BUCKET_MAX = 4,
  parameter int REFILL_DIV = 125000,
  parameter int CNT_W      = 16
) (
  input  logic                  rx_clock,
  input  logic                  reset,
  icmp_rx_scheduler_if.slave    rx,
  input  logic                  cfg_icmp_en,
  input  logic                  cfg_bcast_en,
  input  logic                  resp_busy,
  input  logic                  dst_unreach,
  input  logic                  clear_counters,
  output logic [2:0]            tokens,
  output logic [CNT_W-1:0]      pass_count,
  output logic [CNT_W-1:0]      drop_policy_count,
  output logic [CNT_W-1:0]      drop_busy_count,
  output logic [CNT_W-1:0]      drop_rate_count,
  output logic [CNT_W-1:0]      unreach_count
);

  state_t       state;
  state_t       state_next;
  drop_reason_t reason;
  logic         token_avail;
  logic         is_icmp;
  logic         pkt_start;
  logic         accept;
  logic         forward;

  icmp_token_bucket #(
    .BUCKET_MAX (BUCKET_MAX),
    .REFILL_DIV (REFILL_DIV),
    .TOK_W      (3)
  ) u_bucket (
    .rx_clock (rx_clock),
    .reset    (reset),
    .consume  (accept),
    .tokens   (tokens),
    .nonzero  (token_avail)
  );

  // Classification and next state. Checks are in priority order; a
  // non-ICMP packet is skipped silently without touching any counter.
  always_comb begin
    state_next = state;
    reason     = DROP_NONE;
    is_icmp    = (rx.ip_protocol == IP_PROTO_ICMP);
    pkt_start  = (state == ST_IDLE) && rx.ip_rx_enable;

    if (!cfg_icmp_en || (rx.ip_broadcast && !cfg_bcast_en))
      reason = DROP_POLICY;
    else if (resp_busy)
      reason = DROP_BUSY;
    else if (!token_avail)
      reason = DROP_RATE;

    accept  = pkt_start && is_icmp && (reason == DROP_NONE);
    forward = rx.ip_rx_enable && ((state == ST_PASS) || accept);

    case (state)
      ST_IDLE: if (rx.ip_rx_enable) state_next = accept ? ST_PASS : ST_SKIP;
      ST_PASS: if (!rx.ip_rx_enable) state_next = ST_IDLE;
      ST_SKIP: if (!rx.ip_rx_enable) state_next = ST_IDLE;
      default: state_next = ST_SKIP;
    endcase
  end

  // Reset lands in ST_SKIP so a packet interrupted by reset is discarded
  // to its end instead of being forwarded from the middle.
  always_ff @(posedge rx_clock) begin
    if (reset) begin
      state             <= ST_SKIP;
      rx.icmp_rx_enable <= 1'b0;
      rx.icmp_rx_data   <= '0;
    end else begin
      state             <= state_next;
      rx.icmp_rx_enable <= forward;
      rx.icmp_rx_data   <= rx.ip_rx_data;
    end
  end

  // Statistics; clear takes precedence over any increment in the same cycle.
  always_ff @(posedge rx_clock) begin
    if (reset || clear_counters) begin
      pass_count        <= '0;
      drop_policy_count <= '0;
      drop_busy_count   <= '0;
      drop_rate_count   <= '0;
      unreach_count     <= '0;
    end else begin
      if (accept)
        pass_count <= CNT_W'(sat_inc(32'(pass_count), CNT_W));
      if (pkt_start && is_icmp && (reason == DROP_POLICY))
        drop_policy_count <= CNT_W'(sat_inc(32'(drop_policy_count), CNT_W));
      if (pkt_start && is_icmp && (reason == DROP_BUSY))
        drop_busy_count <= CNT_W'(sat_inc(32'(drop_busy_count), CNT_W));
      if (pkt_start && is_icmp && (reason == DROP_RATE))
        drop_rate_count <= CNT_W'(sat_inc(32'(drop_rate_count), CNT_W));
      if (dst_unreach)
        unreach_count <= CNT_W'(sat_inc(32'(unreach_count), CNT_W));
    end
  end

endmodule

// File: tb/tb_icmp_rx_scheduler.sv
// Self-checking bench for icmp_rx_scheduler: a classification table plus
// hand-written sequences for rate limiting, busy sampling, mid-packet reset,
// counter clear and counter saturation (on a narrow second instance).
module tb_icmp_rx_scheduler;

  logic        rx_clock = 1'b0;
  logic        reset;
  logic        cfg_icmp_en, cfg_bcast_en, resp_busy, dst_unreach, clear_counters;
  logic        dst_unreach2;
  logic [2:0]  tokens, tokens2;
  logic [15:0] pass_count, drop_policy_count, drop_busy_count, drop_rate_count, unreach_count;
  logic [3:0]  pass_count2, drop_policy_count2, drop_busy_count2, drop_rate_count2, unreach_count2;

  int checks = 0;
  int errors = 0;

  icmp_rx_scheduler_if bus ();
  icmp_rx_scheduler_if bus2 ();

  always #5 rx_clock = ~rx_clock;

  icmp_rx_scheduler #(.BUCKET_MAX(4), .REFILL_DIV(100), .CNT_W(16)) dut (
    .rx_clock          (rx_clock),
    .reset             (reset),
    .rx                (bus.slave),
    .cfg_icmp_en       (cfg_icmp_en),
    .cfg_bcast_en      (cfg_bcast_en),
    .resp_busy         (resp_busy),
    .dst_unreach       (dst_unreach),
    .clear_counters    (clear_counters),
    .tokens            (tokens),
    .pass_count        (pass_count),
    .drop_policy_count (drop_policy_count),
    .drop_busy_count   (drop_busy_count),
    .drop_rate_count   (drop_rate_count),
    .unreach_count     (unreach_count)
  );

  // Narrow counters and a fast refill so saturation is reachable quickly.
  icmp_rx_scheduler #(.BUCKET_MAX(4), .REFILL_DIV(2), .CNT_W(4)) dut2 (
    .rx_clock          (rx_clock),
    .reset             (reset),
    .rx                (bus2.slave),
    .cfg_icmp_en       (cfg_icmp_en),
    .cfg_bcast_en      (cfg_bcast_en),
    .resp_busy         (resp_busy),
    .dst_unreach       (dst_unreach2),
    .clear_counters    (clear_counters),
    .tokens            (tokens2),
    .pass_count        (pass_count2),
    .drop_policy_count (drop_policy_count2),
    .drop_busy_count   (drop_busy_count2),
    .drop_rate_count   (drop_rate_count2),
    .unreach_count     (unreach_count2)
  );

  typedef struct {
    logic [7:0] proto;
    logic       bcast;
    logic       icmp_en;
    logic       bcast_en;
    logic       busy;
    int         len;
    int         exp_cycles;
    int         exp_pass;
    int         exp_policy;
    int         exp_busy;
    int         exp_rate;
    logic       chk_tok;
    int         exp_tok;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [7:0] pktByte(input int i);
    if (i == 0) return 8'h08;
    if (i == 1) return 8'h00;
    return 8'(i * 7 + 3);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic resetDut();
    @(negedge rx_clock);
    reset = 1'b1;
    repeat (2) @(negedge rx_clock);
    reset = 1'b0;
  endtask

  // Sends one packet on bus, optionally pulsing reset or changing resp_busy
  // while a given byte index is driven. Counts forwarded cycles and data
  // errors against the one-cycle-delayed input stream.
  task automatic applyStimulus(input int len, input int reset_at, input int busy_at,
                               input logic busy_val, output int en_cycles, output int data_errs);
    en_cycles = 0;
    data_errs = 0;
    @(negedge rx_clock);
    bus.ip_rx_enable = 1'b1;
    bus.ip_rx_data   = pktByte(0);
    if (reset_at == 0) reset = 1'b1;
    if (busy_at == 0) resp_busy = busy_val;
    for (int i = 0; i < len; i++) begin
      @(negedge rx_clock);
      reset = 1'b0;
      if (bus.icmp_rx_enable) begin
        en_cycles++;
        if (bus.icmp_rx_data != pktByte(i)) data_errs++;
      end
      if (i + 1 < len) begin
        bus.ip_rx_data = pktByte(i + 1);
        if (reset_at == i + 1) reset = 1'b1;
        if (busy_at == i + 1) resp_busy = busy_val;
      end else begin
        bus.ip_rx_enable = 1'b0;
        bus.ip_rx_data   = 8'h00;
      end
    end
    repeat (2) begin
      @(negedge rx_clock);
      if (bus.icmp_rx_enable) en_cycles++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc, derr, waited;

    reset = 1'b1;
    cfg_icmp_en = 1'b1; cfg_bcast_en = 1'b1; resp_busy = 1'b0;
    dst_unreach = 1'b0; clear_counters = 1'b0; dst_unreach2 = 1'b0;
    bus.ip_rx_enable = 1'b0; bus.ip_rx_data = 8'h00; bus.ip_protocol = 8'h01; bus.ip_broadcast = 1'b0;
    bus2.ip_rx_enable = 1'b0; bus2.ip_rx_data = 8'h00; bus2.ip_protocol = 8'h01; bus2.ip_broadcast = 1'b0;

    //          proto  bc    icmp  bcen  busy  len cyc pass pol bsy rate chk  tok
    vecs[0] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 40, 40, 1, 0, 0, 0, 1'b1, 3};
    vecs[1] = '{8'h11, 1'b0, 1'b1, 1'b1, 1'b0,  8,  0, 1, 0, 0, 0, 1'b1, 3};
    vecs[2] = '{8'h01, 1'b0, 1'b0, 1'b1, 1'b0,  6,  0, 1, 1, 0, 0, 1'b0, 0};
    vecs[3] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0,  6,  0, 1, 2, 0, 0, 1'b0, 0};
    vecs[4] = '{8'h01, 1'b1, 1'b1, 1'b1, 1'b0,  5,  5, 2, 2, 0, 0, 1'b0, 0};
    vecs[5] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b1,  5,  0, 2, 2, 1, 0, 1'b0, 0};
    vecs[6] = '{8'h11, 1'b0, 1'b0, 1'b1, 1'b1,  4,  0, 2, 2, 1, 0, 1'b0, 0};
    vecs[7] = '{8'h01, 1'b0, 1'b0, 1'b1, 1'b1,  4,  0, 2, 3, 1, 0, 1'b0, 0};
    vecs[8] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0,  1,  1, 3, 3, 1, 0, 1'b0, 0};
    vecs[9] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1,  3,  0, 3, 4, 1, 0, 1'b0, 0};

    // Reset values, sampled while reset is still held.
    repeat (3) @(negedge rx_clock);
    checkOutput("reset_icmp_rx_enable", int'(bus.icmp_rx_enable), 0);
    checkOutput("reset_icmp_rx_data", int'(bus.icmp_rx_data), 0);
    checkOutput("reset_tokens", int'(tokens), 4);
    checkOutput("reset_pass_count", int'(pass_count), 0);
    checkOutput("reset_unreach_count", int'(unreach_count), 0);
    reset = 1'b0;
    $display("[TB] classification table");

    for (int i = 0; i < 10; i++) begin
      bus.ip_protocol  = vecs[i].proto;
      bus.ip_broadcast = vecs[i].bcast;
      cfg_icmp_en      = vecs[i].icmp_en;
      cfg_bcast_en     = vecs[i].bcast_en;
      resp_busy        = vecs[i].busy;
      applyStimulus(vecs[i].len, -1, -1, 1'b0, cyc, derr);
      checkOutput($sformatf("row%0d_enable_cycles", i), cyc, vecs[i].exp_cycles);
      checkOutput($sformatf("row%0d_data_errors", i), derr, 0);
      checkOutput($sformatf("row%0d_pass_count", i), int'(pass_count), vecs[i].exp_pass);
      checkOutput($sformatf("row%0d_drop_policy", i), int'(drop_policy_count), vecs[i].exp_policy);
      checkOutput($sformatf("row%0d_drop_busy", i), int'(drop_busy_count), vecs[i].exp_busy);
      checkOutput($sformatf("row%0d_drop_rate", i), int'(drop_rate_count), vecs[i].exp_rate);
      if (vecs[i].chk_tok)
        checkOutput($sformatf("row%0d_tokens", i), int'(tokens), vecs[i].exp_tok);
    end
    bus.ip_protocol = 8'h01; bus.ip_broadcast = 1'b0;
    cfg_icmp_en = 1'b1; cfg_bcast_en = 1'b1; resp_busy = 1'b0;

    // Rate limit: four tokens, fifth packet inside the refill period drops.
    $display("[TB] rate limit sequence");
    resetDut();
    for (int p = 0; p < 5; p++) begin
      applyStimulus(4, -1, -1, 1'b0, cyc, derr);
      checkOutput($sformatf("rate_pkt%0d_cycles", p), cyc, (p < 4) ? 4 : 0);
    end
    checkOutput("rate_pass_count", int'(pass_count), 4);
    checkOutput("rate_drop_rate", int'(drop_rate_count), 1);
    checkOutput("rate_tokens_empty", int'(tokens), 0);

    waited = 0;
    while (tokens == 3'd0 && waited < 200) begin
      @(negedge rx_clock);
      waited++;
    end
    checkOutput("refill_within_bound", int'(waited < 200), 1);
    checkOutput("refill_tokens_one", int'(tokens), 1);
    // The refill edge was just before this negedge; send a 1-byte packet now.
    bus.ip_rx_enable = 1'b1; bus.ip_rx_data = 8'h08;
    @(negedge rx_clock);
    checkOutput("refill_pkt_forwarded", int'(bus.icmp_rx_enable), 1);
    bus.ip_rx_enable = 1'b0;
    @(negedge rx_clock);
    checkOutput("refill_pkt_tokens", int'(tokens), 0);
    checkOutput("refill_pkt_pass_count", int'(pass_count), 5);
    // Start a packet exactly in the next refill-tick cycle with no tokens.
    repeat (97) @(negedge rx_clock);
    bus.ip_rx_enable = 1'b1; bus.ip_rx_data = 8'h08;
    @(negedge rx_clock);
    checkOutput("tick_empty_forwarded", int'(bus.icmp_rx_enable), 0);
    bus.ip_rx_data = 8'h00;
    @(negedge rx_clock);
    checkOutput("tick_empty_byte2", int'(bus.icmp_rx_enable), 0);
    bus.ip_rx_enable = 1'b0;
    @(negedge rx_clock);
    checkOutput("tick_empty_tokens", int'(tokens), 1);
    checkOutput("tick_empty_drop_rate", int'(drop_rate_count), 2);
    // Consume in the same cycle as the following tick: tokens unchanged.
    repeat (97) @(negedge rx_clock);
    bus.ip_rx_enable = 1'b1; bus.ip_rx_data = 8'h08;
    @(negedge rx_clock);
    checkOutput("tick_consume_forwarded", int'(bus.icmp_rx_enable), 1);
    bus.ip_rx_enable = 1'b0;
    @(negedge rx_clock);
    checkOutput("tick_consume_tokens", int'(tokens), 1);
    checkOutput("tick_consume_pass_count", int'(pass_count), 6);
    repeat (600) @(negedge rx_clock);
    checkOutput("tokens_saturate", int'(tokens), 4);

    // Busy is sampled only at packet start.
    $display("[TB] busy sampling sequence");
    resetDut();
    resp_busy = 1'b1;
    applyStimulus(8, -1, 3, 1'b0, cyc, derr);
    checkOutput("busy_start_cycles", cyc, 0);
    checkOutput("busy_start_drop_busy", int'(drop_busy_count), 1);
    resp_busy = 1'b0;
    applyStimulus(8, -1, 3, 1'b1, cyc, derr);
    checkOutput("busy_mid_cycles", cyc, 8);
    checkOutput("busy_mid_pass_count", int'(pass_count), 1);
    resp_busy = 1'b0;

    // Broadcast policy, then a reset on byte 10 of a passing packet.
    $display("[TB] policy and mid-packet reset sequence");
    resetDut();
    cfg_bcast_en = 1'b0; bus.ip_broadcast = 1'b1;
    applyStimulus(6, -1, -1, 1'b0, cyc, derr);
    checkOutput("bcast_policy_cycles", cyc, 0);
    checkOutput("bcast_policy_count", int'(drop_policy_count), 1);
    cfg_bcast_en = 1'b1; bus.ip_broadcast = 1'b0;
    applyStimulus(20, 9, -1, 1'b0, cyc, derr);
    checkOutput("mid_reset_cycles", cyc, 9);
    checkOutput("mid_reset_data_errors", derr, 0);
    applyStimulus(6, -1, -1, 1'b0, cyc, derr);
    checkOutput("after_reset_cycles", cyc, 6);
    checkOutput("after_reset_pass_count", int'(pass_count), 1);
    checkOutput("after_reset_tokens", int'(tokens), 3);

    // dst_unreach counting and clear priority.
    $display("[TB] unreach and clear sequence");
    @(negedge rx_clock);
    dst_unreach = 1'b1;
    repeat (3) @(negedge rx_clock);
    dst_unreach = 1'b0;
    checkOutput("unreach_three", int'(unreach_count), 3);
    dst_unreach = 1'b1; clear_counters = 1'b1;
    @(negedge rx_clock);
    dst_unreach = 1'b0; clear_counters = 1'b0;
    checkOutput("clear_wins_unreach", int'(unreach_count), 0);
    checkOutput("clear_pass_count", int'(pass_count), 0);
    checkOutput("clear_keeps_tokens", int'(tokens), 3);
    dst_unreach = 1'b1;
    @(negedge rx_clock);
    dst_unreach = 1'b0;
    @(negedge rx_clock);
    checkOutput("unreach_after_clear", int'(unreach_count), 1);

    // Saturation on the 4-bit instance: 18 passes and 20 pulses hold at 15.
    $display("[TB] saturation sequence");
    resetDut();
    for (int k = 0; k < 18; k++) begin
      @(negedge rx_clock);
      bus2.ip_rx_enable = 1'b1; bus2.ip_rx_data = 8'(k);
      @(negedge rx_clock);
      bus2.ip_rx_enable = 1'b0;
    end
    @(negedge rx_clock);
    checkOutput("sat_pass_count", int'(pass_count2), 15);
    checkOutput("sat_drop_rate", int'(drop_rate_count2), 0);
    dst_unreach2 = 1'b1;
    repeat (20) @(negedge rx_clock);
    dst_unreach2 = 1'b0;
    checkOutput("sat_unreach_count", int'(unreach_count2), 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
